// File: rtl/jt12_ch_wrsched.sv
// Write scheduler for the FM core's 6-slot channel ring: buffers up to two channel writes and
// loads each one when its slot enters stage 1. Optional merging of same-channel writes: JT12_WRSCHED_COALESCE_EN.
`timescale 1ns/1ps
module jt12_ch_wrsched #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [2:0]       wr_ch,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] din,
  output logic             load,
  output logic [2:0]       slot,
  output logic             busy,
  output logic             drop
);

  logic [2:0]       r_slot;
  logic             r_drop;
  logic             r_vld  [2];
  logic             r_old  [2];
  logic [2:0]       r_ch   [2];
  logic [width-1:0] r_data [2];

  logic [1:0] w_match;
  logic [1:0] w_iss;
  logic       w_busy;
  logic       w_bad;
  logic       w_merge;
  logic       w_alloc;
  logic       w_free;
  logic       w_drop;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign w_match[gi] = r_vld[gi] && (r_ch[gi] == r_slot);
    end
  endgenerate

  // Only a same-channel pair can match together; the older one goes first.
  assign w_iss[0] = w_match[0] && (!w_match[1] || r_old[0]);
  assign w_iss[1] = w_match[1] && !w_iss[0];

  assign w_busy = r_vld[0] && r_vld[1];
  assign w_bad  = wr && (wr_ch > 3'd5);

`ifdef JT12_WRSCHED_COALESCE_EN
  logic [1:0] w_hit;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit[gi] = r_vld[gi] && (r_ch[gi] == wr_ch) && !w_iss[gi];
    end
  endgenerate
  assign w_merge = wr && !w_bad && (|w_hit);
`else
  assign w_merge = 1'b0;
`endif

  assign w_alloc = wr && !w_bad && !w_merge && !w_busy;
  assign w_drop  = wr && !w_merge && !w_alloc;
  assign w_free  = r_vld[0];

  always_comb begin
    load = 1'b0;
    din  = '0;
    if (|w_iss && !rst) begin
      load = 1'b1;
      din  = w_iss[0] ? r_data[0] : r_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= 3'd0;
      r_drop <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_vld[i] <= 1'b0;
        r_old[i] <= 1'b0;
      end
    end else begin
      r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
      r_drop <= w_drop;
      for (int i = 0; i < 2; i++) begin
        if (w_alloc && (w_free == 1'(i))) begin
          r_vld[i]  <= 1'b1;
          r_old[i]  <= 1'b0;
          r_ch[i]   <= wr_ch;
          r_data[i] <= wr_data;
        end else begin
          if (w_iss[i]) r_vld[i] <= 1'b0;
          // A fresh allocation elsewhere makes this entry the elder.
          if (w_alloc) r_old[i] <= 1'b1;
`ifdef JT12_WRSCHED_COALESCE_EN
          if (w_merge && w_hit[i]) r_data[i] <= wr_data;
`endif
        end
      end
    end
  end

  assign slot = r_slot;
  assign busy = w_busy;
  assign drop = r_drop;

endmodule

// File: tb/tb_jt12_ch_wrsched.sv
// Directed bench for jt12_ch_wrsched: slot rotation, write latency, buffer full, invalid channel,
// same-channel handling (both JT12_WRSCHED_COALESCE_EN builds) and reset mid-operation.
`timescale 1ns/1ps
module tb_jt12_ch_wrsched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [2:0] wr_ch;
  logic [4:0] wr_data;
  logic [4:0] din;
  logic       load;
  logic [2:0] slot;
  logic       busy;
  logic       drop;
  logic [4:0] st1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  jt12_ch_wrsched #(.width(5)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data),
    .din(din), .load(load), .slot(slot), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  // Stand-in for stage 1 of the downstream shift register.
  always_ff @(posedge clk) begin
    if (rst) st1 <= 5'd0;
    else if (load) st1 <= din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("slot", 32'(slot), 32'(cyc % 6));
  endtask

  task automatic wr_on(input logic [2:0] ch, input logic [4:0] data);
    wr = 1'b1; wr_ch = ch; wr_data = data;
    $display("write ch=%0d data=%02h at slot %0d", ch, data, cyc % 6);
  endtask

  task automatic wr_off();
    wr = 1'b0; wr_ch = 3'd0; wr_data = 5'd0;
  endtask

  task automatic idle_until(input int s);
    while (cyc % 6 != s) begin
      tick();
      check("idle_load", 32'(load), 32'd0);
    end
  endtask

  task automatic expect_quiet(input int n, input string tag);
    repeat (n) begin
      tick();
      check(tag, 32'(load), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_off();
    // Reset held for three cycles.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_load", 32'(load), 32'd0);
      check("rst_din", 32'(din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
    check("slot0", 32'(slot), 32'd0);
    repeat (6) begin
      tick();
      check("rot_load", 32'(load), 32'd0);
      check("rot_busy", 32'(busy), 32'd0);
    end

    // Single write: slot 1, ch 4, loads at slot 4.
    idle_until(1);
    wr_on(3'd4, 5'h13);
    tick(); wr_off();
    check("sw_load_s2", 32'(load), 32'd0);
    tick();
    check("sw_load_s3", 32'(load), 32'd0);
    tick();
    check("sw_load", 32'(load), 32'd1);
    check("sw_din", 32'(din), 32'h13);
    tick();
    check("sw_st1", 32'(st1), 32'h13);
    check("sw_load_after", 32'(load), 32'd0);

    // Same-slot write: waits a full rotation.
    idle_until(2);
    wr_on(3'd2, 5'h0A);
    tick(); wr_off();
    check("ss_load_s3", 32'(load), 32'd0);
    expect_quiet(4, "ss_quiet");
    tick();
    check("ss_load", 32'(load), 32'd1);
    check("ss_din", 32'(din), 32'h0A);
    tick();
    check("ss_st1", 32'(st1), 32'h0A);

`ifndef JT12_WRSCHED_COALESCE_EN
    // Full buffer with two ch5 writes; the ch3 write is dropped.
    idle_until(0);
    wr_on(3'd5, 5'h11);
    tick();
    wr_on(3'd5, 5'h12);
    check("fb_busy_s1", 32'(busy), 32'd0);
    tick();
    check("fb_busy_s2", 32'(busy), 32'd1);
    wr_on(3'd3, 5'h07);
    tick(); wr_off();
    check("fb_drop", 32'(drop), 32'd1);
    check("fb_busy_s3", 32'(busy), 32'd1);
    tick();
    check("fb_drop_clr", 32'(drop), 32'd0);
    check("fb_load_s4", 32'(load), 32'd0);
    tick();
    check("fb_load1", 32'(load), 32'd1);
    check("fb_din1", 32'(din), 32'h11);
    tick();
    check("fb_load_s0", 32'(load), 32'd0);
    check("fb_busy_s0", 32'(busy), 32'd0);
    expect_quiet(4, "fb_quiet");
    tick();
    check("fb_load2", 32'(load), 32'd1);
    check("fb_din2", 32'(din), 32'h12);
    tick();
    check("fb_busy_end", 32'(busy), 32'd0);
`endif

    // Two writes to ch3 at slots 0 and 1.
    idle_until(0);
    wr_on(3'd3, 5'h01);
    tick();
    wr_on(3'd3, 5'h02);
    check("co_busy_s1", 32'(busy), 32'd0);
    tick(); wr_off();
    check("co_drop", 32'(drop), 32'd0);
`ifdef JT12_WRSCHED_COALESCE_EN
    check("co_busy_s2", 32'(busy), 32'd0);
    tick();
    check("co_load", 32'(load), 32'd1);
    check("co_din", 32'(din), 32'h02);
    check("co_drop_s3", 32'(drop), 32'd0);
    expect_quiet(6, "co_quiet");
`else
    check("co_busy_s2", 32'(busy), 32'd1);
    tick();
    check("co_load1", 32'(load), 32'd1);
    check("co_din1", 32'(din), 32'h01);
    expect_quiet(5, "co_quiet");
    tick();
    check("co_load2", 32'(load), 32'd1);
    check("co_din2", 32'(din), 32'h02);
`endif

    // Busy with an issue in the same cycle: the freed entry is not reused.
    idle_until(0);
    wr_on(3'd2, 5'h02);
    tick();
    wr_on(3'd4, 5'h04);
    tick();
    wr_on(3'd1, 5'h01);
    check("bi_busy", 32'(busy), 32'd1);
    check("bi_load", 32'(load), 32'd1);
    check("bi_din", 32'(din), 32'h02);
    tick(); wr_off();
    check("bi_drop", 32'(drop), 32'd1);
    check("bi_busy_s3", 32'(busy), 32'd0);
    tick();
    check("bi_load2", 32'(load), 32'd1);
    check("bi_din2", 32'(din), 32'h04);
    expect_quiet(4, "bi_quiet");

    // Invalid channels with one entry pending.
    idle_until(0);
    wr_on(3'd5, 5'h15);
    tick();
    wr_on(3'd7, 5'h1F);
    tick(); wr_off();
    check("inv7_drop", 32'(drop), 32'd1);
    check("inv7_busy", 32'(busy), 32'd0);
    tick();
    wr_on(3'd6, 5'h1E);
    check("inv_drop_clr", 32'(drop), 32'd0);
    tick(); wr_off();
    check("inv6_drop", 32'(drop), 32'd1);
    check("inv6_busy", 32'(busy), 32'd0);
    check("inv_load_s4", 32'(load), 32'd0);
    tick();
    check("inv_load", 32'(load), 32'd1);
    check("inv_din", 32'(din), 32'h15);
    expect_quiet(6, "inv_quiet");

    // Reset while an entry is pending.
    idle_until(0);
    wr_on(3'd4, 5'h09);
    tick(); wr_off();
    rst = 1'b1;
    check("mr_load_rst", 32'(load), 32'd0);
    @(posedge clk); #1;
    check("mr_slot_rst", 32'(slot), 32'd0);
    check("mr_load_rst2", 32'(load), 32'd0);
    check("mr_busy_rst", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc = 0;
    check("mr_slot0", 32'(slot), 32'd0);
    check("mr_load0", 32'(load), 32'd0);
    expect_quiet(7, "mr_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
